// File: rtl/led_pattern_seq.sv
// led_pattern_seq: prescaled LED pattern sequencer for a bank of N_LEDS outputs.
// Patterns: BIN_UP, BIN_DOWN, ROTATE, BOUNCE; run/pause, single-step and a
// wrap strobe marking the return to the pattern seed.
// Optional PWM dimming of o_leds is enabled by defining LED_SEQ_PWM_EN
// (adds the i_duty input and one cycle of output latency).
module led_pattern_seq #(
    parameter int unsigned N_LEDS   = 5,
    parameter int unsigned TICK_DIV = 6000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_run,
    input  logic              i_step,
`ifdef LED_SEQ_PWM_EN
    input  logic [7:0]        i_duty,
`endif
    output logic              o_tick,
    output logic              o_wrap,
    output logic [N_LEDS-1:0] o_leds
);

    localparam int unsigned       PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]     PRESC_ONE  = PW'(1);
    localparam logic [N_LEDS-1:0] LSB_ONE    = {{(N_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        BIN_UP   = 2'd0,
        BIN_DOWN = 2'd1,
        ROTATE   = 2'd2,
        BOUNCE   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PW-1:0]     r_presc;
    mode_t             r_mode;
    dir_t              r_dir;
    logic [N_LEDS-1:0] r_pattern;

    mode_t             w_mode_in;
    logic              w_mode_chg;
    logic              w_adv;
    logic              w_onehot;
    logic              w_wrap;
    logic [N_LEDS-1:0] w_next;
    dir_t              w_next_dir;

    function automatic logic [N_LEDS-1:0] seed(input mode_t m);
        case (m)
            BIN_UP:   seed = '0;
            BIN_DOWN: seed = '1;
            default:  seed = LSB_ONE;
        endcase
    endfunction

    assign w_mode_in  = mode_t'(i_mode);
    assign w_mode_chg = (w_mode_in != r_mode);
    // Step requests are only honoured while paused.
    assign w_adv      = i_run ? (r_presc == PRESC_LAST) : i_step;
    assign w_onehot   = (r_pattern != '0) && ((r_pattern & (r_pattern - LSB_ONE)) == '0);

    // Next pattern, bounce direction and wrap flag for the current mode.
    always_comb begin
        w_next     = r_pattern;
        w_next_dir = r_dir;
        w_wrap     = 1'b0;
        case (r_mode)
            BIN_UP: begin
                w_next = r_pattern + LSB_ONE;
                w_wrap = (r_pattern == '1);
            end
            BIN_DOWN: begin
                w_next = r_pattern - LSB_ONE;
                w_wrap = (r_pattern == '0);
            end
            ROTATE: begin
                if (w_onehot) begin
                    w_next = {r_pattern[N_LEDS-2:0], r_pattern[N_LEDS-1]};
                    w_wrap = r_pattern[N_LEDS-1];
                end else begin
                    w_next = LSB_ONE;
                end
            end
            BOUNCE: begin
                if (!w_onehot) begin
                    w_next     = LSB_ONE;
                    w_next_dir = DIR_UP;
                end else if (r_dir == DIR_UP) begin
                    if (r_pattern[N_LEDS-1]) begin
                        w_next     = r_pattern >> 1;
                        w_next_dir = DIR_DOWN;
                    end else begin
                        w_next = r_pattern << 1;
                    end
                end else begin
                    if (r_pattern[0]) begin
                        w_next     = r_pattern << 1;
                        w_next_dir = DIR_UP;
                    end else begin
                        w_next = r_pattern >> 1;
                    end
                end
                // Round trip completes on the bit1 -> bit0 step.
                w_wrap = w_onehot && r_pattern[1] && w_next[0];
            end
            default: begin
                w_next = r_pattern;
            end
        endcase
    end

    // Prescaler, mode tracking, pattern register and strobes.
    // Reset and mode change load identical state, so they share one branch.
    always_ff @(posedge clk) begin
        if (!rst_n || w_mode_chg) begin
            r_presc   <= '0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
            r_mode    <= w_mode_in;
            r_pattern <= seed(w_mode_in);
            r_dir     <= DIR_UP;
        end else if (w_adv) begin
            r_presc   <= '0;
            o_tick    <= 1'b1;
            o_wrap    <= w_wrap;
            r_pattern <= w_next;
            r_dir     <= w_next_dir;
        end else begin
            o_tick <= 1'b0;
            o_wrap <= 1'b0;
            if (i_run) begin
                r_presc <= r_presc + PRESC_ONE;
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic       w_pwm_on;

    assign w_pwm_on = (r_pwm_cnt < i_duty);

    // Free-running PWM counter and gated, registered LED outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            o_leds    <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            o_leds    <= r_pattern & {N_LEDS{w_pwm_on}};
        end
    end
`else
    assign o_leds = r_pattern;
`endif

endmodule
